// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
// STOP_BITS follows the FIFO_UART_TX_STOP2_EN compile-time option.
package fifo_uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

`ifdef FIFO_UART_TX_STOP2_EN
  localparam int STOP_BITS = 2;
`else
  localparam int STOP_BITS = 1;
`endif

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/fifo_uart_tx_parity.sv
// Combinational parity bit for one payload word: even or odd total count
// of ones across data plus the parity bit itself.
module tx_parity_calc
  import fifo_uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_type,
  output logic                  par_bit
);

  assign par_bit = (^data) ^ (par_type == PAR_ODD);

endmodule

// File: rtl/fifo_uart_tx.sv
// UART frame serializer popping bytes from a show-ahead FIFO, one bit per clock.
// Define FIFO_UART_TX_STOP2_EN for two stop bits (default is one).
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic [DATA_WIDTH-1:0] i_RD_DATA,
  input  logic                  i_EMPTY,
  input  logic                  i_Par_En,
  input  logic                  i_Par_Type,
  output logic                  o_RD_INC,
  output logic                  o_TX_OUT,
  output logic                  o_Busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  tx_state_t             state;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  stop_cnt;
  logic                  frame_par_en;
  logic                  frame_par_bit;
  logic                  calc_par_bit;

  tx_parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity (
    .data    (i_RD_DATA),
    .par_type(i_Par_Type),
    .par_bit (calc_par_bit)
  );

  // A pop is only possible from idle or the final stop bit, and never while in reset.
  assign o_RD_INC = i_RST && !i_EMPTY &&
                    ((state == IDLE) || ((state == STOP) && (stop_cnt == STOP_LAST)));

  // o_TX_OUT is loaded with the value of the bit the next state puts on the line.
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      state         <= IDLE;
      shift_reg     <= '0;
      bit_cnt       <= '0;
      stop_cnt      <= 1'b0;
      frame_par_en  <= 1'b0;
      frame_par_bit <= 1'b0;
      o_TX_OUT      <= 1'b1;
      o_Busy        <= 1'b0;
    end else if (o_RD_INC) begin
      shift_reg     <= i_RD_DATA;
      frame_par_en  <= i_Par_En;
      frame_par_bit <= calc_par_bit;
      bit_cnt       <= '0;
      stop_cnt      <= 1'b0;
      state         <= START;
      o_TX_OUT      <= 1'b0;
      o_Busy        <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          o_TX_OUT <= 1'b1;
          o_Busy   <= 1'b0;
        end
        START: begin
          state     <= DATA;
          bit_cnt   <= '0;
          o_TX_OUT  <= shift_reg[0];
          shift_reg <= shift_reg >> 1;
        end
        DATA: begin
          if (bit_cnt == CNT_LAST) begin
            bit_cnt <= '0;
            if (frame_par_en) begin
              state    <= PARITY;
              o_TX_OUT <= frame_par_bit;
            end else begin
              state    <= STOP;
              stop_cnt <= 1'b0;
              o_TX_OUT <= 1'b1;
            end
          end else begin
            bit_cnt   <= bit_cnt + 1'b1;
            o_TX_OUT  <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
          end
        end
        PARITY: begin
          state    <= STOP;
          stop_cnt <= 1'b0;
          o_TX_OUT <= 1'b1;
        end
        STOP: begin
          if (stop_cnt == STOP_LAST) begin
            state    <= IDLE;
            o_TX_OUT <= 1'b1;
            o_Busy   <= 1'b0;
          end else begin
            stop_cnt <= stop_cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          o_TX_OUT <= 1'b1;
          o_Busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: table vectors, hand-written corner
// sequences and randomized streams against a frame-level reference model.
module tb_fifo_uart_tx;
  import fifo_uart_tx_pkg::STOP_BITS;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rd_data;
  logic       empty;
  logic       par_en;
  logic       par_type;
  logic       rd_inc;
  logic       tx_out;
  logic       busy;

  fifo_uart_tx #(
    .DATA_WIDTH(8)
  ) dut (
    .i_CLK     (clk),
    .i_RST     (rst_n),
    .i_RD_DATA (rd_data),
    .i_EMPTY   (empty),
    .i_Par_En  (par_en),
    .i_Par_Type(par_type),
    .o_RD_INC  (rd_inc),
    .o_TX_OUT  (tx_out),
    .o_Busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    bit         en;
    bit         typ;
    bit         exp_par;
    int         exp_len;
    string      name;
  } vec_t;

  vec_t       vecs[9];
  int         checks = 0;
  int         failures = 0;
  logic [7:0] fifo_q[$];
  int         pops = 0;
  int         busy_cycles = 0;
  logic [7:0] fd[4];
  bit         fen[4];
  bit         ftyp[4];
  bit         fpar[4];
  int         fn = 1;
  logic       exp_tx[$];
  logic       exp_busy[$];
  logic       exp_rd[$];

  task automatic checkOutput(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic checkCount(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit modelParity(input logic [7:0] d, input bit typ);
    return ((($countones(d) % 2) == 1) ? 1'b1 : 1'b0) ^ typ;
  endfunction

  // Drive the FIFO view and the config of the frame that will be loaded next.
  task automatic applyStimulus();
    int idx;
    @(negedge clk);
    idx      = (pops < fn) ? pops : fn - 1;
    empty    = (fifo_q.size() == 0);
    rd_data  = empty ? 8'h00 : fifo_q[0];
    par_en   = fen[idx];
    par_type = ftyp[idx];
    #1;
  endtask

  task automatic pushStep(input logic t, input logic b, input logic r);
    exp_tx.push_back(t);
    exp_busy.push_back(b);
    exp_rd.push_back(r);
  endtask

  // Reference: each frame is start, LSB-first data, optional parity, stop bits.
  task automatic buildExpected();
    logic frame[$];
    exp_tx.delete();
    exp_busy.delete();
    exp_rd.delete();
    for (int i = 0; i < fn; i++) begin
      if (i == 0) pushStep(1'b1, 1'b0, 1'b1);
      frame.delete();
      frame.push_back(1'b0);
      for (int j = 0; j < 8; j++) frame.push_back(fd[i][j]);
      if (fen[i]) frame.push_back(fpar[i]);
      for (int s = 0; s < STOP_BITS; s++) frame.push_back(1'b1);
      for (int j = 0; j < frame.size(); j++)
        pushStep(frame[j], 1'b1, (j == frame.size() - 1) && (i < fn - 1));
    end
    pushStep(1'b1, 1'b0, 1'b0);
  endtask

  task automatic runFrames(input string tag);
    fifo_q.delete();
    for (int i = 0; i < fn; i++) fifo_q.push_back(fd[i]);
    pops = 0;
    busy_cycles = 0;
    buildExpected();
    for (int k = 0; k < exp_tx.size(); k++) begin
      applyStimulus();
      checkOutput($sformatf("%s tx step%0d", tag, k), tx_out, exp_tx[k]);
      checkOutput($sformatf("%s busy step%0d", tag, k), busy, exp_busy[k]);
      checkOutput($sformatf("%s rd_inc step%0d", tag, k), rd_inc, exp_rd[k]);
      if (busy === 1'b1) busy_cycles++;
      if (rd_inc === 1'b1) begin
        pops++;
        if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      end
    end
    checkCount($sformatf("%s pops", tag), pops, fn);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int idle_pulses;

    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 10, "a5_nopar"};
    vecs[1] = '{8'hA5, 1'b1, 1'b0, 1'b0, 11, "a5_even"};
    vecs[2] = '{8'hA5, 1'b1, 1'b1, 1'b1, 11, "a5_odd"};
    vecs[3] = '{8'h00, 1'b1, 1'b0, 1'b0, 11, "00_even"};
    vecs[4] = '{8'h00, 1'b1, 1'b1, 1'b1, 11, "00_odd"};
    vecs[5] = '{8'hFF, 1'b1, 1'b0, 1'b0, 11, "ff_even"};
    vecs[6] = '{8'h80, 1'b1, 1'b0, 1'b1, 11, "80_even"};
    vecs[7] = '{8'h7F, 1'b1, 1'b1, 1'b0, 11, "7f_odd"};
    vecs[8] = '{8'h55, 1'b0, 1'b0, 1'b0, 10, "55_nopar"};

    rst_n    = 1'b0;
    empty    = 1'b1;
    rd_data  = 8'h00;
    par_en   = 1'b0;
    par_type = 1'b0;
    fen[0]   = 1'b0;
    ftyp[0]  = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset tx", tx_out, 1'b1);
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset rd_inc", rd_inc, 1'b0);
    empty   = 1'b0;
    rd_data = 8'hAA;
    #1;
    checkOutput("reset no pop", rd_inc, 1'b0);
    empty = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    foreach (vecs[v]) begin
      fn      = 1;
      fd[0]   = vecs[v].data;
      fen[0]  = vecs[v].en;
      ftyp[0] = vecs[v].typ;
      fpar[0] = vecs[v].exp_par;
      runFrames(vecs[v].name);
      checkCount({vecs[v].name, " len"}, busy_cycles, vecs[v].exp_len + STOP_BITS - 1);
    end

    // ALU LSB/MSB pair sent back to back with even parity
    fn = 2;
    fd[0] = 8'h80; fen[0] = 1'b1; ftyp[0] = 1'b0; fpar[0] = 1'b1;
    fd[1] = 8'h01; fen[1] = 1'b1; ftyp[1] = 1'b0; fpar[1] = 1'b1;
    runFrames("b2b");
    checkCount("b2b busy len", busy_cycles, 2 * (10 + STOP_BITS));

    // Parity enable drops mid first frame; only the second frame loses parity
    fn = 2;
    fd[0] = 8'hA5; fen[0] = 1'b1; ftyp[0] = 1'b0; fpar[0] = 1'b0;
    fd[1] = 8'h3C; fen[1] = 1'b0; ftyp[1] = 1'b0; fpar[1] = 1'b0;
    runFrames("par_toggle");
    checkCount("par_toggle len", busy_cycles, 21 + 2 * (STOP_BITS - 1));

    for (int r = 0; r < 6; r++) begin
      fn = $urandom_range(1, 4);
      for (int i = 0; i < fn; i++) begin
        fd[i]   = 8'($urandom);
        fen[i]  = 1'($urandom_range(0, 1));
        ftyp[i] = 1'($urandom_range(0, 1));
        fpar[i] = modelParity(fd[i], ftyp[i]);
      end
      runFrames($sformatf("rand%0d", r));
    end

    // Reset lands on data bit 4 of 0x3C with another byte still queued
    fifo_q.delete();
    fifo_q.push_back(8'h3C);
    fifo_q.push_back(8'h96);
    fn = 2;
    fen[0] = 1'b0; ftyp[0] = 1'b0;
    fen[1] = 1'b0; ftyp[1] = 1'b0;
    pops = 0;
    for (int k = 0; k <= 6; k++) begin
      applyStimulus();
      if (k == 6) begin
        checkOutput("rst pre bit4 tx", tx_out, 1'b1);
        checkOutput("rst pre busy", busy, 1'b1);
      end
      if (rd_inc === 1'b1) begin
        pops++;
        if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      end
    end
    rst_n = 1'b0;
    #1;
    checkOutput("rst async tx", tx_out, 1'b1);
    checkOutput("rst async busy", busy, 1'b0);
    checkOutput("rst async rd_inc", rd_inc, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("rst hold busy", busy, 1'b0);
    checkCount("rst pops", pops, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    fn = 1;
    fd[0] = 8'h96; fen[0] = 1'b1; ftyp[0] = 1'b1; fpar[0] = 1'b1;
    runFrames("post_rst");

    // Empty FIFO must never see a pop strobe
    fifo_q.delete();
    fn = 1;
    fen[0] = 1'b0; ftyp[0] = 1'b0;
    idle_pulses = 0;
    for (int k = 0; k < 20; k++) begin
      applyStimulus();
      if (rd_inc !== 1'b0) idle_pulses++;
    end
    checkCount("idle no pop", idle_pulses, 0);
    checkOutput("idle tx", tx_out, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
